// File: rtl/ace_master_ctrl.sv
// ace_master_ctrl: ACE master-side transaction sequencer for a cache controller.
// Runs write (AW/W/B), read-shared / make-unique (AR/R) and snoop (AC/CR[/CD])
// transactions. A failed or timed-out response is retried up to MAX_RETRY
// times before the transaction aborts.
// Build option: define ACE_SNOOP_DATA_EN to add the CD snoop data phase after a
// dirty snoop hit. When it is undefined, CD_VALID is tied low and every snoop
// ends after the CR handshake.
module ace_master_ctrl #(
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic clk,
    input  logic rst_n,
    // cache-controller side
    input  logic write_req,
    input  logic read_req,
    input  logic invalid_req,
    output logic ace_ready,
    output logic ace_error,
    // datapath side
    input  logic B_okay,
    input  logic R_okay,
    input  logic snoop_miss,
    input  logic snoop_dirty,
    output logic write_clean_o,
    output logic read_shared_o,
    output logic make_unique_o,
    // write channels
    output logic AW_VALID,
    input  logic AW_READY,
    output logic W_VALID,
    input  logic W_READY,
    input  logic B_VALID,
    output logic B_READY,
    // read channels
    output logic AR_VALID,
    input  logic AR_READY,
    input  logic R_VALID,
    output logic R_READY,
    // snoop channels
    input  logic AC_VALID,
    output logic AC_READY,
    output logic CR_VALID,
    input  logic CR_READY,
    output logic CD_VALID,
    input  logic CD_READY
);

    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned TMO_W   = 16;

    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WADDR    = 3'd1,
        S_WDATA    = 3'd2,
        S_BRESP    = 3'd3,
        S_RADDR    = 3'd4,
        S_RDATA    = 3'd5,
`ifdef ACE_SNOOP_DATA_EN
        S_SNP_RESP = 3'd6,
        S_SNP_DATA = 3'd7
`else
        S_SNP_RESP = 3'd6
`endif
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE      = 2'd0,
        OP_WRITE     = 2'd1,
        OP_RD_SHARED = 2'd2,
        OP_MK_UNIQUE = 2'd3
    } op_e;

    state_e               state_q;
    op_e                  op_q;
    logic [RETRY_W-1:0]   retry_q;
    logic [TMO_W-1:0]     tmo_q;
    logic                 snp_miss_q;
    logic                 snp_dirty_q;

    logic resp_wait_c;
    logic resp_valid_c;
    logic resp_okay_c;
    logic tmo_hit_c;
    logic resp_done_c;
    logic resp_fail_c;
    logic retry_left_c;
    logic abort_c;

    // Response evaluation for whichever response channel is being waited on
    assign resp_wait_c  = (state_q == S_BRESP) || (state_q == S_RDATA);
    assign resp_valid_c = (state_q == S_BRESP) ? B_VALID : R_VALID;
    assign resp_okay_c  = (state_q == S_BRESP) ? B_okay  : R_okay;
    assign tmo_hit_c    = (tmo_q == TMO_LAST);
    assign resp_done_c  = resp_wait_c && resp_valid_c && resp_okay_c;
    assign resp_fail_c  = resp_wait_c && (resp_valid_c ? !resp_okay_c : tmo_hit_c);
    assign retry_left_c = (retry_q < RETRY_MAX);
    assign abort_c      = resp_fail_c && !retry_left_c;

    // Sequencer: state, latched op / snoop result, retry and timeout counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NONE;
            retry_q     <= '0;
            tmo_q       <= '0;
            snp_miss_q  <= 1'b0;
            snp_dirty_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    retry_q <= '0;
                    tmo_q   <= '0;
                    if (AC_VALID) begin
                        snp_miss_q  <= snoop_miss;
                        snp_dirty_q <= snoop_dirty;
                        state_q     <= S_SNP_RESP;
                    end else if (write_req) begin
                        op_q    <= OP_WRITE;
                        state_q <= S_WADDR;
                    end else if (read_req) begin
                        op_q    <= OP_RD_SHARED;
                        state_q <= S_RADDR;
                    end else if (invalid_req) begin
                        op_q    <= OP_MK_UNIQUE;
                        state_q <= S_RADDR;
                    end
                end

                S_WADDR: begin
                    if (AW_READY) begin
                        state_q <= S_WDATA;
                    end
                end

                S_WDATA: begin
                    if (W_READY) begin
                        tmo_q   <= '0;
                        state_q <= S_BRESP;
                    end
                end

                S_RADDR: begin
                    if (AR_READY) begin
                        tmo_q   <= '0;
                        state_q <= S_RDATA;
                    end
                end

                S_BRESP, S_RDATA: begin
                    if (resp_done_c) begin
                        op_q    <= OP_NONE;
                        state_q <= S_IDLE;
                    end else if (resp_fail_c) begin
                        if (retry_left_c) begin
                            retry_q <= retry_q + RETRY_W'(1);
                            state_q <= (op_q == OP_WRITE) ? S_WADDR : S_RADDR;
                        end else begin
                            op_q    <= OP_NONE;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end

                S_SNP_RESP: begin
                    if (CR_READY) begin
`ifdef ACE_SNOOP_DATA_EN
                        if (!snp_miss_q && snp_dirty_q) begin
                            state_q <= S_SNP_DATA;
                        end else begin
                            snp_miss_q  <= 1'b0;
                            snp_dirty_q <= 1'b0;
                            state_q     <= S_IDLE;
                        end
`else
                        snp_miss_q  <= 1'b0;
                        snp_dirty_q <= 1'b0;
                        state_q     <= S_IDLE;
`endif
                    end
                end

`ifdef ACE_SNOOP_DATA_EN
                S_SNP_DATA: begin
                    if (CD_READY) begin
                        snp_miss_q  <= 1'b0;
                        snp_dirty_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
`endif

                default: begin
                    op_q    <= OP_NONE;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Channel handshake outputs decoded from the registered state
    assign AC_READY = (state_q == S_IDLE);
    assign AW_VALID = (state_q == S_WADDR);
    assign W_VALID  = (state_q == S_WDATA);
    assign B_READY  = (state_q == S_BRESP);
    assign AR_VALID = (state_q == S_RADDR);
    assign R_READY  = (state_q == S_RDATA);
    assign CR_VALID = (state_q == S_SNP_RESP);

`ifdef ACE_SNOOP_DATA_EN
    assign CD_VALID = (state_q == S_SNP_DATA);
`else
    // Snoop data phase not built; latched snoop result and CD_READY have no reader
    logic unused_c;
    assign CD_VALID = 1'b0;
    assign unused_c = ^{CD_READY, snp_miss_q, snp_dirty_q};
`endif

    // Datapath op select, held for the whole transaction (OP_NONE in IDLE)
    assign write_clean_o = (op_q == OP_WRITE);
    assign read_shared_o = (op_q == OP_RD_SHARED);
    assign make_unique_o = (op_q == OP_MK_UNIQUE);

    // Completion pulses, valid in the response cycle that ends the transaction
    assign ace_ready = resp_done_c || abort_c;
    assign ace_error = abort_c;

endmodule

// File: tb/tb_ace_master_ctrl.sv
// tb_ace_master_ctrl: scoreboard bench for ace_master_ctrl (MAX_RETRY=3, TIMEOUT=8).
// Expected completion status is queued when a request is issued and popped when
// ace_ready pulses; cycle-level behaviour is checked directly in the test flow.
module tb_ace_master_ctrl;

    localparam int unsigned MAX_RETRY = 3;
    localparam int unsigned TIMEOUT   = 8;

    logic clk;
    logic rst_n;
    logic write_req, read_req, invalid_req;
    logic ace_ready, ace_error;
    logic B_okay, R_okay, snoop_miss, snoop_dirty;
    logic write_clean_o, read_shared_o, make_unique_o;
    logic AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
    logic AR_VALID, AR_READY, R_VALID, R_READY;
    logic AC_VALID, AC_READY, CR_VALID, CR_READY, CD_VALID, CD_READY;

    int   n_vec = 0;
    int   n_err = 0;
    logic exp_q[$];
    int   ar_hs = 0;
    int   aw_hs = 0;
    int   r_hs_cnt = 0;
    logic r_hs_n = 1'b0;
    int   r_fail_until = 0;

    ace_master_ctrl #(
        .MAX_RETRY (MAX_RETRY),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .write_req     (write_req),
        .read_req      (read_req),
        .invalid_req   (invalid_req),
        .ace_ready     (ace_ready),
        .ace_error     (ace_error),
        .B_okay        (B_okay),
        .R_okay        (R_okay),
        .snoop_miss    (snoop_miss),
        .snoop_dirty   (snoop_dirty),
        .write_clean_o (write_clean_o),
        .read_shared_o (read_shared_o),
        .make_unique_o (make_unique_o),
        .AW_VALID      (AW_VALID),
        .AW_READY      (AW_READY),
        .W_VALID       (W_VALID),
        .W_READY       (W_READY),
        .B_VALID       (B_VALID),
        .B_READY       (B_READY),
        .AR_VALID      (AR_VALID),
        .AR_READY      (AR_READY),
        .R_VALID       (R_VALID),
        .R_READY       (R_READY),
        .AC_VALID      (AC_VALID),
        .AC_READY      (AC_READY),
        .CR_VALID      (CR_VALID),
        .CR_READY      (CR_READY),
        .CD_VALID      (CD_VALID),
        .CD_READY      (CD_READY)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Read responder: R_okay low until the requested number of R handshakes has passed
    assign R_okay = (r_hs_cnt >= r_fail_until);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: handshake counters and scoreboard pop on ace_ready
    always @(negedge clk) begin
        logic e;
        if (AR_VALID && AR_READY) ar_hs++;
        if (AW_VALID && AW_READY) aw_hs++;
        r_hs_n = R_VALID && R_READY;
        if (ace_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_ready", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_ace_error", ace_error, e);
            end
        end else if (ace_error === 1'b1) begin
            check("ace_error_without_ready", 1, 0);
        end
    end

    always @(posedge clk) begin
        #1;
        if (r_hs_n) r_hs_cnt++;
    end

    task automatic issue(input int kind);
        @(posedge clk); #1;
        case (kind)
            0:       write_req   = 1'b1;
            1:       read_req    = 1'b1;
            default: invalid_req = 1'b1;
        endcase
        @(negedge clk);
    endtask

    task automatic finish_req();
        @(posedge clk); #1;
        write_req   = 1'b0;
        read_req    = 1'b0;
        invalid_req = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_ready(input int budget, output int n);
        n = 0;
        while (ace_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (ace_ready !== 1'b1) check("wait_ready_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;

        rst_n = 1'b0;
        write_req = 1'b0; read_req = 1'b0; invalid_req = 1'b0;
        B_okay = 1'b1; snoop_miss = 1'b0; snoop_dirty = 1'b0;
        AW_READY = 1'b1; W_READY = 1'b1; B_VALID = 1'b1;
        AR_READY = 1'b1; R_VALID = 1'b1;
        AC_VALID = 1'b0; CR_READY = 1'b1; CD_READY = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_ac_ready", AC_READY, 1);
        check("rst_aw_valid", AW_VALID, 0);
        check("rst_ar_valid", AR_VALID, 0);
        check("rst_cr_valid", CR_VALID, 0);
        check("rst_cd_valid", CD_VALID, 0);
        check("rst_ace_ready", ace_ready, 0);
        check("rst_ops", {write_clean_o, read_shared_o, make_unique_o}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Write, everything ready: AW cycle 1, W cycle 2, ace_ready cycle 3
        exp_q.push_back(1'b0);
        issue(0);
        check("w_c0_aw_valid", AW_VALID, 0);
        check("w_c0_ac_ready", AC_READY, 1);
        step();
        check("w_c1_aw_valid", AW_VALID, 1);
        check("w_c1_write_clean", write_clean_o, 1);
        check("w_c1_ac_ready", AC_READY, 0);
        step();
        check("w_c2_w_valid", W_VALID, 1);
        check("w_c2_aw_valid", AW_VALID, 0);
        step();
        check("w_c3_b_ready", B_READY, 1);
        check("w_c3_ace_ready", ace_ready, 1);
        check("w_c3_ace_error", ace_error, 0);
        finish_req();

        // Write with B_okay=0 every time: four AW handshakes then abort
        B_okay = 1'b0;
        base = aw_hs;
        exp_q.push_back(1'b1);
        issue(0);
        wait_ready(100, n);
        check("wabort_latency", n, 12);
        check("wabort_aw_hs", aw_hs - base, 4);
        finish_req();
        B_okay = 1'b1;

        // Read with R_okay=0 every time: four AR handshakes then abort
        r_fail_until = 32'h7fff_ffff;
        base = ar_hs;
        exp_q.push_back(1'b1);
        issue(1);
        wait_ready(100, n);
        check("rabort_latency", n, 8);
        check("rabort_ar_hs", ar_hs - base, 4);
        check("rabort_error", ace_error, 1);
        finish_req();

        // Read succeeding first time: read_shared op, ready in cycle 2
        r_fail_until = r_hs_cnt;
        exp_q.push_back(1'b0);
        issue(1);
        step();
        check("rd_c1_ar_valid", AR_VALID, 1);
        check("rd_c1_read_shared", read_shared_o, 1);
        check("rd_c1_make_unique", make_unique_o, 0);
        step();
        check("rd_c2_r_ready", R_READY, 1);
        check("rd_c2_ace_ready", ace_ready, 1);
        finish_req();

        // Read failing exactly MAX_RETRY times then succeeding (retry count starts from 0)
        r_fail_until = r_hs_cnt + 3;
        base = ar_hs;
        exp_q.push_back(1'b0);
        issue(1);
        wait_ready(100, n);
        check("rlast_latency", n, 8);
        check("rlast_ar_hs", ar_hs - base, 4);
        finish_req();
        r_fail_until = r_hs_cnt;

        // Make-unique with no R_VALID: 8 RDATA cycles per attempt, then AR again
        R_VALID = 1'b0;
        exp_q.push_back(1'b1);
        issue(2);
        for (int c = 1; c <= 36; c++) begin
            int p;
            step();
            p = (c - 1) % 9;
            check($sformatf("inv_ar_valid_c%0d", c), AR_VALID, (p == 0) ? 1 : 0);
            check($sformatf("inv_r_ready_c%0d", c), R_READY, (p != 0) ? 1 : 0);
            check($sformatf("inv_make_unique_c%0d", c), make_unique_o, 1);
        end
        check("inv_abort_ready", ace_ready, 1);
        finish_req();
        R_VALID = 1'b1;

        // Snoop and write in the same IDLE cycle, dirty hit: snoop wins
        snoop_miss  = 1'b0;
        snoop_dirty = 1'b1;
        exp_q.push_back(1'b0);
        @(posedge clk); #1;
        AC_VALID  = 1'b1;
        write_req = 1'b1;
        @(negedge clk);
        check("snp_c0_ac_ready", AC_READY, 1);
        @(posedge clk); #1;
        AC_VALID = 1'b0;
        @(negedge clk);
        check("snp_c1_cr_valid", CR_VALID, 1);
        check("snp_c1_ac_ready", AC_READY, 0);
        check("snp_c1_aw_valid", AW_VALID, 0);
`ifdef ACE_SNOOP_DATA_EN
        step();
        check("snp_c2_cd_valid", CD_VALID, 1);
        check("snp_c2_cr_valid", CR_VALID, 0);
        step();
        check("snp_c3_ac_ready", AC_READY, 1);
        check("snp_c3_aw_valid", AW_VALID, 0);
        step();
        check("snp_c4_aw_valid", AW_VALID, 1);
`else
        step();
        check("snp_c2_cd_valid", CD_VALID, 0);
        check("snp_c2_ac_ready", AC_READY, 1);
        step();
        check("snp_c3_aw_valid", AW_VALID, 1);
        check("snp_c3_cd_valid", CD_VALID, 0);
`endif
        wait_ready(20, n);
        check("snp_write_latency", n, 2);
        finish_req();

        // Clean hit and dirty miss: no data phase, CR held under backpressure
        for (int k = 0; k < 2; k++) begin
            snoop_miss  = (k == 1);
            snoop_dirty = (k == 1);
            CR_READY    = 1'b0;
            @(posedge clk); #1;
            AC_VALID = 1'b1;
            @(negedge clk);
            @(posedge clk); #1;
            AC_VALID = 1'b0;
            @(negedge clk);
            check($sformatf("snp%0d_c1_cr_valid", k), CR_VALID, 1);
            step();
            check($sformatf("snp%0d_c2_cr_hold", k), CR_VALID, 1);
            CR_READY = 1'b1;
            step();
            check($sformatf("snp%0d_c3_cd_valid", k), CD_VALID, 0);
            check($sformatf("snp%0d_c3_ac_ready", k), AC_READY, 1);
        end

        // AW backpressure: AW_VALID held until AW_READY
        AW_READY = 1'b0;
        exp_q.push_back(1'b0);
        issue(0);
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("awbp_c%0d_aw_valid", k), AW_VALID, 1);
        end
        AW_READY = 1'b1;
        wait_ready(20, n);
        check("awbp_latency", n, 2);
        finish_req();

        // Reset asserted in WDATA with W_READY=0
        W_READY = 1'b0;
        issue(0);
        step();
        check("rstw_c1_aw_valid", AW_VALID, 1);
        step();
        check("rstw_c2_w_valid", W_VALID, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstw_w_valid", W_VALID, 0);
        check("rstw_ac_ready", AC_READY, 1);
        check("rstw_ace_ready", ace_ready, 0);
        check("rstw_write_clean", write_clean_o, 0);
        write_req = 1'b0;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        W_READY = 1'b1;
        repeat (3) step();
        check("rstw_idle_ac_ready", AC_READY, 1);

        check("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
